mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Runs a small FSM that serialises accesses, returns read data to the winning requester, and drives the pipeline freeze controls (pc_hold, per-register write enables) while either stage waits. MEM has priority over IF, with an optional starvation guard.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF and MEM accesses onto one fixed-latency single-port memory and drives pipeline freeze controls.
// Optional starvation guard enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_arbiter #(
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        ram_en,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        pc_hold,
   output logic        if_id_irwr,
   output logic        id_ex_irwr,
   output logic        ex_mem_irwr,
   output logic        mem_wb_irwr
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        ram_we_q, ram_we_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdata_q, ram_wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        grant_mem;
   logic        mem_stall, if_stall;

   if (LAT < 1 || LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
      $error("mem_arbiter: LAT and STARVE_MAX must lie in 1..15");
   end

`ifdef MEMARB_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;
   // IF is forced through once MEM has beaten it STARVE_MAX times in a row
   assign grant_mem = mem_req && !(if_req && starve_q == 4'(STARVE_MAX));
   always_comb
      starve_d = (state_q != IDLE) ? starve_q :
                 (grant_mem && if_req) ? starve_q + 4'd1 :
                 if_req ? 4'd0 : starve_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
`else
   assign grant_mem = mem_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         IDLE: if (mem_req || if_req) begin
            state_d     = ISSUE;
            owner_d     = grant_mem;
            ram_addr_d  = grant_mem ? mem_addr : if_addr;
            ram_we_d    = grant_mem && mem_we;
            ram_wdata_d = grant_mem ? mem_wdata : ram_wdata_q;
         end
         ISSUE: begin
            cnt_d   = 4'(LAT - 1);
            state_d = WAIT;
         end
         WAIT: if (cnt_q == 4'd0) begin
            state_d     = RESP;
            if_rdata_d  = owner_q ? if_rdata_q : ram_rdata;
            mem_rdata_d = !owner_q ? mem_rdata_q : ram_we_q ? 32'd0 : ram_rdata;
         end else
            cnt_d = cnt_q - 4'd1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end

   assign ram_en    = state_q == ISSUE;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_ready  = state_q == RESP && !owner_q;
   assign mem_ready = state_q == RESP && owner_q;

   // a MEM stall freezes the whole pipe; an IF stall only bubbles IF/ID
   always_comb begin
      mem_stall   = mem_req && !mem_ready;
      if_stall    = if_req && !if_ready;
      pc_hold     = rst || mem_stall || if_stall;
      if_id_irwr  = !pc_hold;
      id_ex_irwr  = !(rst || mem_stall);
      ex_mem_irwr = !(rst || mem_stall);
      mem_wb_irwr = !(rst || mem_stall);
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random IF/MEM traffic against a transaction-level timing model, plus a directed LAT=1 corner.
module tb_mem_arbiter;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_req = 0, mem_req = 0, mem_we = 0;
   logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, ram_rdata = 0;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
   logic        if_ready, mem_ready, ram_en, ram_we, pc_hold;
   logic        if_id_irwr, id_ex_irwr, ex_mem_irwr, mem_wb_irwr;

   logic        l1_mem_req = 0, l1_mem_we = 0;
   logic [31:0] l1_mem_addr = 0, l1_mem_wdata = 0, l1_ram_rdata = 0;
   logic [31:0] l1_if_rdata, l1_mem_rdata, l1_ram_addr, l1_ram_wdata;
   logic        l1_if_ready, l1_mem_ready, l1_ram_en, l1_ram_we, l1_pc_hold;
   logic        l1_if_id, l1_id_ex, l1_ex_mem, l1_mem_wb;

   mem_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .pc_hold(pc_hold),
      .if_id_irwr(if_id_irwr), .id_ex_irwr(id_ex_irwr),
      .ex_mem_irwr(ex_mem_irwr), .mem_wb_irwr(mem_wb_irwr)
   );

   mem_arbiter #(.LAT(1), .STARVE_MAX(SMAX)) u_l1 (
      .clk(clk), .rst(rst),
      .if_req(1'b0), .if_addr(32'h0), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
      .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(l1_mem_rdata), .mem_ready(l1_mem_ready),
      .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr), .ram_wdata(l1_ram_wdata),
      .ram_rdata(l1_ram_rdata), .pc_hold(l1_pc_hold),
      .if_id_irwr(l1_if_id), .id_ex_irwr(l1_id_ex),
      .ex_mem_irwr(l1_ex_mem), .mem_wb_irwr(l1_mem_wb)
   );

   int checks = 0, errors = 0, cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
      end
   endtask

   logic [31:0] ram [16];
   logic [31:0] ref_mem [16];
   logic [31:0] rd_val, g_addr, g_wdata, g_rd, exp_if_rd, exp_mem_rd;
   int          rd_due = -1, g = -100, starve = 0, rst_cnt = 0;
   bit          busy, busy0, own, g_we, forced, force_if;
   bit          if_act, if_wait, mem_act, mem_wait;
   bit          exp_en, exp_ifr, exp_memr, if_st, mem_st;

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram[i]     = 32'h8C01_0004 + i * 32'h0100_0101;
         ref_mem[i] = ram[i];
      end
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk); #1;
         cyc = k;
         ram_rdata = (k == rd_due) ? rd_val : $urandom();
         if (rst_cnt == 0 && (k < 3 || $urandom_range(0, 249) == 0 ||
             (!forced && busy && own && !g_we && k == g + 2))) begin
            rst_cnt = (k < 3) ? 1 : $urandom_range(1, 2);
            if (busy && own && k == g + 2) forced = 1;
         end
         rst = rst_cnt != 0;
         if (rst_cnt != 0) rst_cnt--;
         if (rst) begin
            busy = 0; starve = 0; exp_if_rd = 0; exp_mem_rd = 0;
            if_act = 0; if_wait = 0; mem_act = 0; mem_wait = 0;
         end else begin
            if (!if_act && !if_wait && $urandom_range(0, 2) == 0) begin
               if_act = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
            end else if (if_act && if_wait && $urandom_range(0, 7) == 0) if_act = 0;
            if (!if_act) if_addr = $urandom();
            if (!mem_act && !mem_wait && $urandom_range(0, 1) == 0) begin
               mem_act = 1; mem_addr = $urandom() & 32'hFFFF_FFFC;
               mem_we = 1'($urandom_range(0, 1)); mem_wdata = $urandom();
            end else if (mem_act && mem_wait && $urandom_range(0, 7) == 0) mem_act = 0;
            if (!mem_act) begin
               mem_addr = $urandom(); mem_wdata = $urandom(); mem_we = 1'($urandom_range(0, 1));
            end
         end
         if_req = if_act; mem_req = mem_act;
         @(negedge clk);
         if (rst) begin
            check("rst_ram_en", ram_en, 0);
            check("rst_ready", {if_ready, mem_ready}, 0);
            check("rst_pc_hold", pc_hold, 1);
            check("rst_irwr", {if_id_irwr, id_ex_irwr, ex_mem_irwr, mem_wb_irwr}, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_mem_rdata", mem_rdata, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            check("rst_ram_we", ram_we, 0);
         end else begin
            busy0    = busy;
            exp_en   = busy && k == g + 1;
            exp_ifr  = busy && !own && k == g + 2 + LAT;
            exp_memr = busy && own && k == g + 2 + LAT;
            if (exp_en) begin
               g_rd = g_we ? 32'h0 : ref_mem[g_addr[5:2]];
               if (g_we) ref_mem[g_addr[5:2]] = g_wdata;
            end
            if (exp_ifr) exp_if_rd = g_rd;
            if (exp_memr) exp_mem_rd = g_rd;
            check("ram_en", ram_en, exp_en);
            if (exp_en) begin
               check("ram_addr", ram_addr, g_addr);
               check("ram_we", ram_we, g_we);
               if (g_we) check("ram_wdata", ram_wdata, g_wdata);
            end
            check("if_ready", if_ready, exp_ifr);
            check("mem_ready", mem_ready, exp_memr);
            check("if_rdata", if_rdata, exp_if_rd);
            check("mem_rdata", mem_rdata, exp_mem_rd);
            mem_st = mem_req && !exp_memr;
            if_st  = if_req && !exp_ifr;
            check("pc_hold", pc_hold, mem_st || if_st);
            check("irwr", {if_id_irwr, id_ex_irwr, ex_mem_irwr, mem_wb_irwr},
                  mem_st ? 4'b0000 : if_st ? 4'b0111 : 4'b1111);
            if (exp_ifr) begin if_act = 0; if_wait = 0; end
            if (exp_memr) begin mem_act = 0; mem_wait = 0; end
            if (busy && k == g + 2 + LAT) busy = 0;
            if (!busy0 && (if_req || mem_req)) begin
`ifdef MEMARB_STARVE_GUARD_EN
               force_if = if_req && mem_req && starve == SMAX;
`else
               force_if = 0;
`endif
               own = mem_req && !force_if;
               if (own && if_req) starve++;
               if (!own) starve = 0;
               busy = 1; g = k;
               g_addr  = own ? mem_addr : if_addr;
               g_we    = own && mem_we;
               g_wdata = mem_wdata;
               if (own) mem_wait = 1; else if_wait = 1;
            end
         end
         if (ram_en === 1'b1) begin
            rd_due = k + LAT;
            rd_val = ram[ram_addr[5:2]];
            if (ram_we) ram[ram_addr[5:2]] = ram_wdata;
         end
      end
      rst = 0; if_req = 0; mem_req = 0;
      // LAT=1: data sampled in cycle 2, ready in cycle 3
      for (int t = 0; t < 2; t++)
         for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            cyc = 5000 + t * 10 + c;
            if (c == 0) begin
               l1_mem_req = 1; l1_mem_we = 1'(t);
               l1_mem_addr = 32'h20; l1_mem_wdata = 32'hCAFE_0000 + t;
            end
            if (c == 4) l1_mem_req = 0;
            l1_ram_rdata = (c == 2) ? 32'h1234_5678 : $urandom();
            @(negedge clk);
            check("l1_ram_en", l1_ram_en, c == 1);
            if (c == 1) begin
               check("l1_ram_we", l1_ram_we, t);
               check("l1_ram_addr", l1_ram_addr, 32'h20);
            end
            check("l1_mem_ready", l1_mem_ready, c == 3);
            if (c == 3) check("l1_mem_rdata", l1_mem_rdata, t == 1 ? 32'h0 : 32'h1234_5678);
            check("l1_pc_hold", l1_pc_hold, c < 3);
         end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
